// File: rtl/fetch_unit.sv
// Instruction fetch front end: issues sequential fetches under a credit rule
// and buffers {pc, instr} responses in a small prefetch FIFO, with branch redirect.
module fetch_unit #(
  parameter int              PC_W     = 32,
  parameter int              INSTR_W  = 32,
  parameter logic [PC_W-1:0] PC_RESET = '0,
  parameter int              PC_STEP  = 4,
  parameter int              DEPTH    = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   br_taken,
  input  logic [PC_W-1:0]        br_target,
  output logic                   imem_req,
  output logic [PC_W-1:0]        imem_addr,
  input  logic [INSTR_W-1:0]     imem_rdata,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [PC_W-1:0]        out_pc,
  output logic [INSTR_W-1:0]     out_instr,
  output logic [$clog2(DEPTH):0] fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [PC_W-1:0]    fetch_pc;
  logic [PC_W-1:0]    inflight_pc;
  logic               inflight;
  logic               kill;
  logic [AW-1:0]      rd_ptr;
  logic [AW-1:0]      wr_ptr;
  logic [CW-1:0]      count;
  logic [PC_W-1:0]    pc_mem    [DEPTH];
  logic [INSTR_W-1:0] instr_mem [DEPTH];

  logic               pop;
  logic               push;
  logic [CW:0]        credit_used;
  logic [CW:0]        credit_limit;

  assign out_valid  = (count != '0);
  assign pop        = out_valid & out_ready;
  assign push       = inflight & ~kill & ~br_taken;
  assign fifo_count = count;
  assign out_pc     = pc_mem[rd_ptr];
  assign out_instr  = instr_mem[rd_ptr];
  assign imem_addr  = fetch_pc;

  // A request is only issued when a FIFO slot is guaranteed for its response,
  // counting the slot freed by this cycle's pop. Compared as used < limit to avoid underflow.
  assign credit_used  = {1'b0, count} + {{CW{1'b0}}, inflight};
  assign credit_limit = (CW+1)'(DEPTH) + {{CW{1'b0}}, pop};
  assign imem_req     = rst & ~br_taken & (credit_used < credit_limit);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc    <= PC_RESET;
      inflight_pc <= '0;
      inflight    <= 1'b0;
      kill        <= 1'b0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
    end else if (br_taken) begin
      // Redirect beats push, pop and sequential advance; the response of the
      // request in flight this cycle is simply not pushed.
      fetch_pc <= br_target;
      inflight <= 1'b0;
      kill     <= 1'b1;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      kill     <= 1'b0;
      inflight <= imem_req;
      if (imem_req) begin
        fetch_pc    <= fetch_pc + PC_W'(PC_STEP);
        inflight_pc <= fetch_pc;
      end
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array has no reset; out_valid (count != 0) masks stale contents.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]    <= inflight_pc;
      instr_mem[wr_ptr] <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: queue-level reference model compared every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_fetch_unit;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        br_taken = 1'b0;
  logic [31:0] br_target = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic [2:0]  fifo_count;

  // Second instance with a PC_RESET near the top of the address space
  logic        h_req;
  logic [31:0] h_addr;
  logic [31:0] h_rdata;
  logic        h_valid;
  logic [31:0] h_pc;
  logic [31:0] h_instr;
  logic [2:0]  h_count;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fetch_unit u_dut (
    .clk(clk), .rst(rst), .br_taken(br_taken), .br_target(br_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_instr(out_instr), .fifo_count(fifo_count)
  );

  fetch_unit #(.PC_RESET(32'hFFFF_FFF8)) u_dut_hi (
    .clk(clk), .rst(rst), .br_taken(1'b0), .br_target(32'h0),
    .imem_req(h_req), .imem_addr(h_addr), .imem_rdata(h_rdata),
    .out_valid(h_valid), .out_ready(1'b1), .out_pc(h_pc),
    .out_instr(h_instr), .fifo_count(h_count)
  );

  // Instruction memory: the returned word is the previous cycle's address
  always @(posedge clk) begin
    imem_rdata <= imem_addr;
    h_rdata    <= h_addr;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: program-order queues of PCs
  logic [31:0] m_fifo [$];
  logic [31:0] m_infl [$];
  logic [31:0] m_pc;
  logic        s_pop, s_req, s_br;
  logic [31:0] s_tgt;

  task automatic model_reset();
    m_fifo.delete();
    m_infl.delete();
    m_pc = 32'h0;
  endtask

  always @(negedge clk) begin
    int used;
    if (!rst) model_reset();
    s_pop = (m_fifo.size() != 0) && out_ready;
    used  = m_fifo.size() + m_infl.size() - (s_pop ? 1 : 0);
    s_req = rst && !br_taken && (used < DEPTH);
    s_br  = br_taken;
    s_tgt = br_target;
    check("out_valid",  32'(out_valid),  32'(m_fifo.size() != 0));
    check("fifo_count", 32'(fifo_count), 32'(m_fifo.size()));
    check("imem_req",   32'(imem_req),   32'(s_req));
    check("imem_addr",  imem_addr,       m_pc);
    if (m_fifo.size() != 0) begin
      check("out_pc",    out_pc,    m_fifo[0]);
      check("out_instr", out_instr, m_fifo[0]);
    end
  end

  always @(posedge clk) begin
    if (!rst) begin
      model_reset();
    end else if (s_br) begin
      m_fifo.delete();
      m_infl.delete();
      m_pc = s_tgt;
    end else begin
      if (s_pop) void'(m_fifo.pop_front());
      if (m_infl.size() != 0) m_fifo.push_back(m_infl[0]);
      m_infl.delete();
      if (s_req) begin
        m_infl.push_back(m_pc);
        m_pc = m_pc + 32'd4;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic hold_reset(input logic ready);
    rst = 1'b0;
    br_taken = 1'b0;
    out_ready = ready;
    tick();
    tick();
  endtask

  initial begin
    tick();
    tick();

    // Streaming from reset, plus wrap-around on the high instance
    hold_reset(1'b1);
    rst = 1'b1;
    #1;
    check("s1_req0",  32'(imem_req), 32'h1);
    check("s1_addr0", imem_addr, 32'h0);
    check("wrap0", h_addr, 32'hFFFF_FFF8);
    tick(); #1;
    check("s1_addr1",  imem_addr, 32'h4);
    check("s1_valid1", 32'(out_valid), 32'h0);
    check("wrap1", h_addr, 32'hFFFF_FFFC);
    tick(); #1;
    check("s1_valid2", 32'(out_valid), 32'h1);
    check("s1_pc2", out_pc, 32'h0);
    check("wrap2", h_addr, 32'h0000_0000);
    tick(); #1;
    check("s1_pc3", out_pc, 32'h4);
    check("wrap3", h_addr, 32'h0000_0004);
    repeat (10) tick();

    // Back-pressure from reset: exactly four requests, then drain with no gap
    hold_reset(1'b0);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("s2_req", 32'(imem_req), 32'h1);
      check("s2_addr", imem_addr, 32'(4 * i));
      tick();
    end
    tick();
    tick(); #1;
    check("s2_count", 32'(fifo_count), 32'h4);
    check("s2_req_stall", 32'(imem_req), 32'h0);
    check("s2_addr_hold", imem_addr, 32'h10);
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      check("s2_drain_valid", 32'(out_valid), 32'h1);
      check("s2_drain_pc", out_pc, 32'(4 * i));
      tick();
    end

    // Asynchronous reset with a full FIFO
    hold_reset(1'b0);
    rst = 1'b1;
    repeat (6) tick();
    check("s6_full", 32'(fifo_count), 32'h4);
    rst = 1'b0;
    #1;
    check("s6_valid", 32'(out_valid), 32'h0);
    check("s6_req", 32'(imem_req), 32'h0);
    check("s6_count", 32'(fifo_count), 32'h0);
    tick();
    tick();
    out_ready = 1'b1;
    rst = 1'b1;
    #1;
    check("s6_restart_req", 32'(imem_req), 32'h1);
    check("s6_restart_addr", imem_addr, 32'h0);
    tick();
    tick(); #1;
    check("s6_first_pc", out_pc, 32'h0);
    repeat (4) tick();

    // Redirect with 3 buffered + 1 in flight
    hold_reset(1'b0);
    rst = 1'b1;
    repeat (4) tick();
    check("s3_count3", 32'(fifo_count), 32'h3);
    br_taken = 1'b1;
    br_target = 32'h100;
    #1;
    check("s3_no_req", 32'(imem_req), 32'h0);
    tick();
    br_taken = 1'b0;
    #1;
    check("s3_count0", 32'(fifo_count), 32'h0);
    check("s3_valid0", 32'(out_valid), 32'h0);
    check("s3_req", 32'(imem_req), 32'h1);
    check("s3_addr", imem_addr, 32'h100);
    out_ready = 1'b1;
    tick();
    tick(); #1;
    check("s3_pc0", out_pc, 32'h100);
    tick(); #1;
    check("s3_pc1", out_pc, 32'h104);
    repeat (4) tick();

    // Redirect coinciding with a pop at fifo_count=2
    hold_reset(1'b0);
    rst = 1'b1;
    repeat (3) tick();
    check("s4_count2", 32'(fifo_count), 32'h2);
    out_ready = 1'b1;
    br_taken = 1'b1;
    br_target = 32'h100;
    tick();
    br_taken = 1'b0;
    #1;
    check("s4_count0", 32'(fifo_count), 32'h0);
    check("s4_addr", imem_addr, 32'h100);
    tick();
    tick(); #1;
    check("s4_pc0", out_pc, 32'h100);
    tick(); #1;
    check("s4_pc1", out_pc, 32'h104);

    // Randomized traffic with redirects and occasional resets
    for (int i = 0; i < 3000; i++) begin
      tick();
      out_ready = ($urandom_range(0, 3) != 0);
      br_taken  = ($urandom_range(0, 9) == 0);
      br_target = $urandom & 32'hFFFF_FFFC;
      rst       = ($urandom_range(0, 199) != 0);
    end
    rst = 1'b1;
    br_taken = 1'b0;
    repeat (4) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
